stick_filter: RTL and testbench
===============================

# stick_filter

Conditions the raw 8-bit SAR ADC result for one gamepad stick axis before it reaches the controller protocol serializer. It captures the ADC result on a fixed sample period and computes a 4-sample moving average. It then applies a calibrated center, a symmetric deadzone and saturation, and presents a centered 8-bit axis value with a one-cycle update strobe. One instance sits directly downstream of each adc_sar instance.

## Interface
- sample_period, 16'd1024: cycles between ADC captures. Must exceed one full ADC conversion. Legal range 4..65535.
- deadzone, 8'd4: offsets with |offset| <= deadzone are output as center.
- CLK  in  1  system clock, same clock as the ADC.
- RESET  in  1  asynchronous, active-low reset.
- ADC_IN  in  8  ADC DIGITAL_OUT, registered on CLK upstream.
- CAL_REQ  in  1  recenter request from a button. Asynchronous level; the rising edge is the request.
- STICK_OUT  out  8  conditioned axis value, center = 8'h80.
- STICK_VALID  out  1  one-cycle pulse when STICK_OUT updates.
- CAL_DONE  out  1  one-cycle pulse when a new center is latched.

## Operation
- Sample timer: a 16-bit down-counter loaded with sample_period-1. At 0 it asserts internal tick for one cycle and reloads.
- Capture, on edge with tick:
  - ADC_IN is written into a 4-entry ring at wr_ptr (2-bit, wraps 3->0).
  - Sum is 10-bit unsigned: sum <= sum - ring[wr_ptr] + ADC_IN.
  - fill (0..4) increments, saturating at 4.
  - Ring entries reset to 0, so the sum is exact from reset.
- Average: avg = sum[9:2], truncating.
- Compute stage, edge after a capture where fill==4:
  - offset = {1'b0,avg} - {1'b0,center}, 9-bit signed.
  - If cal_pending: center <= avg, offset forced to 0, cal_pending cleared, CAL_DONE pulses.
- Output stage, next edge:
  - If |offset| <= deadzone: STICK_OUT <= 8'h80.
  - Else: r = 128 + offset, computed at 10 bits signed. r<0 gives 8'h00; r>255 gives 8'hFF; otherwise r[7:0].
  - STICK_VALID pulses in the same cycle.
- No output update and no STICK_VALID while fill<4.
- CAL_REQ path: a 2-flop synchronizer, then rising-edge detect, sets cal_pending.
  - A pending request is held until the first compute stage with fill==4.
  - Further edges while pending merge into it.
- A new center does not clear the ring or fill.

## Timing
- Reset values, applied asynchronously and immediately:
  - STICK_OUT=8'h80, STICK_VALID=0, CAL_DONE=0.
  - center=8'h80, sum=0, ring=0, fill=0, wr_ptr=0, cal_pending=0, sync flops=0.
  - Timer loaded with sample_period-1.
- After deassertion, the first tick occurs sample_period cycles later.
- Latency: capture at edge N, offset/center at N+1, STICK_OUT and STICK_VALID at N+2. CAL_DONE is asserted at N+1.
- First STICK_VALID: the 4th tick after reset, plus 2 edges.
- STICK_VALID period equals sample_period; it never asserts in two consecutive cycles.
- CAL_REQ edge to cal_pending: 3 edges (2 sync + detect). A request arriving after compute edge N+1 applies at the next sample.
- Reset mid-pipeline discards in-flight capture, offset and pending calibration. No STICK_VALID or CAL_DONE pulse may follow a reset without 4 fresh captures.
- ADC_IN is sampled only on tick edges. Between ticks it may change freely.

## Test plan
- Reset: assert RESET low mid-run with STICK_OUT=8'hA0. STICK_OUT must read 8'h80 and the pulses 0 before the next CLK edge. Release, then hold ADC_IN=8'hA0 with sample_period=8. Exactly 4 ticks are needed, and the first STICK_VALID occurs 34 cycles after release with STICK_OUT=8'hA0.
- Deadzone at default center: steady 8'h84 must give 8'h80. Steady 8'h85 must give 8'h85. Steady 8'h7C must give 8'h80. Steady 8'h7B must give 8'h7B.
- Averaging: captures 8'h80,8'h80,8'h80,8'h90 (sum 10'h210, avg 8'h84) must give 8'h80. A 5th capture of 8'h90 (sum 10'h220, avg 8'h88) must give 8'h88. Check wr_ptr wrap by 8 further captures of 8'h40, which must settle at 8'h40.
- Calibration: steady 8'h90, pulse CAL_REQ for 1 cycle. The next update must give CAL_DONE=1 at capture+1 and STICK_OUT=8'h80. Subsequent steady 8'h90 must stay at 8'h80. Steady 8'h00 must give 8'h00 (offset -144, clamped).
- Clamp high: calibrate at steady 8'h40, then steady 8'hFF. Offset is +191, r=319, so STICK_OUT must be 8'hFF.
- CAL_REQ during fill<4: assert 5 cycles after reset. cal_pending must be held, then CAL_DONE must pulse once, together with the first valid update. Three rapid CAL_REQ edges before that update must still produce a single CAL_DONE.

Source files
------------

// File: rtl/stick_filter.sv
// Gamepad stick axis conditioner: periodic ADC capture, 4-sample moving average,
// calibrated center, symmetric deadzone and saturation to a centered 8-bit value.
module stick_filter #(
  parameter logic [15:0] sample_period = 16'd1024,
  parameter logic [7:0]  deadzone      = 8'd4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] ADC_IN,
  input  logic       CAL_REQ,
  output logic [7:0] STICK_OUT,
  output logic       STICK_VALID,
  output logic       CAL_DONE
);

  localparam logic [15:0] RELOAD = sample_period - 16'd1;

  // Handshake: STICK_VALID is a one-cycle strobe with STICK_OUT stable from that
  // cycle until the next strobe; CAL_DONE precedes the matching strobe by one cycle.

  logic [15:0]     timer_q, timer_d;
  logic [3:0][7:0] ring_q, ring_d;
  logic [1:0]      wr_ptr_q, wr_ptr_d;
  logic [9:0]      sum_q, sum_d;
  logic [2:0]      fill_q, fill_d;
  logic            cap_q, cap_d;
  logic [7:0]      center_q, center_d;
  logic [8:0]      offset_q, offset_d;
  logic            off_valid_q, off_valid_d;
  logic            cal_pending_q, cal_pending_d;
  logic            sync1_q, sync2_q, sync3_q;
  logic            cal_done_q, cal_done_d;
  logic [7:0]      stick_out_q, stick_out_d;
  logic            stick_valid_q, stick_valid_d;

  logic       tick;
  logic       compute;
  logic       cal_rise;
  logic [7:0] avg;
  logic [8:0] off_mag;
  logic [9:0] r;

  assign tick     = (timer_q == 16'd0);
  assign avg      = sum_q[9:2];
  assign compute  = cap_q && (fill_q == 3'd4);
  assign cal_rise = sync2_q & ~sync3_q;

  always_comb begin
    timer_d  = tick ? RELOAD : (timer_q - 16'd1);
    ring_d   = ring_q;
    wr_ptr_d = wr_ptr_q;
    sum_d    = sum_q;
    fill_d   = fill_q;
    cap_d    = tick;
    if (tick) begin
      // Replace the oldest entry so the running sum stays exact without re-adding.
      ring_d[wr_ptr_q] = ADC_IN;
      wr_ptr_d         = wr_ptr_q + 2'd1;
      sum_d            = sum_q - {2'b00, ring_q[wr_ptr_q]} + {2'b00, ADC_IN};
      if (fill_q != 3'd4) fill_d = fill_q + 3'd1;
    end
  end

  always_comb begin
    offset_d      = offset_q;
    center_d      = center_q;
    off_valid_d   = compute;
    cal_done_d    = 1'b0;
    cal_pending_d = cal_pending_q | cal_rise;
    if (compute) begin
      if (cal_pending_q) begin
        center_d      = avg;
        offset_d      = 9'd0;
        cal_done_d    = 1'b1;
        // An edge landing on the consuming cycle is kept for the next sample.
        cal_pending_d = cal_rise;
      end else begin
        offset_d = {1'b0, avg} - {1'b0, center_q};
      end
    end
  end

  always_comb begin
    off_mag       = offset_q[8] ? (9'd0 - offset_q) : offset_q;
    r             = 10'd128 + {offset_q[8], offset_q};
    stick_out_d   = stick_out_q;
    stick_valid_d = off_valid_q;
    if (off_valid_q) begin
      if (off_mag <= {1'b0, deadzone}) stick_out_d = 8'h80;
      else if (r[9])                   stick_out_d = 8'h00;
      else if (r[8])                   stick_out_d = 8'hFF;
      else                             stick_out_d = r[7:0];
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      timer_q       <= RELOAD;
      ring_q        <= '0;
      wr_ptr_q      <= 2'd0;
      sum_q         <= 10'd0;
      fill_q        <= 3'd0;
      cap_q         <= 1'b0;
      center_q      <= 8'h80;
      offset_q      <= 9'd0;
      off_valid_q   <= 1'b0;
      cal_pending_q <= 1'b0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      sync3_q       <= 1'b0;
      cal_done_q    <= 1'b0;
      stick_out_q   <= 8'h80;
      stick_valid_q <= 1'b0;
    end else begin
      timer_q       <= timer_d;
      ring_q        <= ring_d;
      wr_ptr_q      <= wr_ptr_d;
      sum_q         <= sum_d;
      fill_q        <= fill_d;
      cap_q         <= cap_d;
      center_q      <= center_d;
      offset_q      <= offset_d;
      off_valid_q   <= off_valid_d;
      cal_pending_q <= cal_pending_d;
      sync1_q       <= CAL_REQ;
      sync2_q       <= sync1_q;
      sync3_q       <= sync2_q;
      cal_done_q    <= cal_done_d;
      stick_out_q   <= stick_out_d;
      stick_valid_q <= stick_valid_d;
    end
  end

  assign STICK_OUT   = stick_out_q;
  assign STICK_VALID = stick_valid_q;
  assign CAL_DONE    = cal_done_q;

endmodule

// File: tb/tb_stick_filter.sv
// Bench for stick_filter with an 8-cycle sample period: directed samples push
// {cal_done, stick_out} expectations; a negedge monitor pops them on STICK_VALID.
module tb_stick_filter;

  logic       CLK;
  logic       RESET;
  logic [7:0] ADC_IN;
  logic       CAL_REQ;
  logic [7:0] STICK_OUT;
  logic       STICK_VALID;
  logic       CAL_DONE;

  logic [8:0]  exp_q[$];
  logic [16:0] vecs[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  int cal_seen = 0;
  int upd_idx = 0;
  int first_valid;
  logic prev_valid = 1'b0;
  logic prev_cal = 1'b0;

  stick_filter #(.sample_period(16'd8), .deadzone(8'd4)) dut (
    .CLK(CLK), .RESET(RESET), .ADC_IN(ADC_IN), .CAL_REQ(CAL_REQ),
    .STICK_OUT(STICK_OUT), .STICK_VALID(STICK_VALID), .CAL_DONE(CAL_DONE)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // driver: one sample slot of 8 cycles, optional 1-cycle CAL_REQ pulse at its start
  task automatic sample(input logic [7:0] adc, input logic do_push, input logic [7:0] exp_out,
                        input logic exp_cal, input logic cal_pulse);
    ADC_IN = adc;
    if (do_push) exp_q.push_back({exp_cal, exp_out});
    if (cal_pulse) begin
      CAL_REQ = 1'b1;
      @(posedge CLK); #1;
      CAL_REQ = 1'b0;
      repeat (7) @(posedge CLK);
    end else begin
      repeat (8) @(posedge CLK);
    end
    #1;
  endtask

  // monitor / scoreboard
  always @(negedge CLK) begin
    if (!RESET) begin
      prev_valid = 1'b0;
      prev_cal   = 1'b0;
    end else begin
      if (CAL_DONE) cal_seen++;
      if (STICK_VALID) begin
        upd_idx++;
        if (exp_q.size() == 0) begin
          check($sformatf("unexpected_valid#%0d", upd_idx), 32'd1, 32'd0);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check($sformatf("stick_out#%0d", upd_idx), {24'd0, STICK_OUT}, {24'd0, e[7:0]});
          check($sformatf("cal_done#%0d", upd_idx), {31'd0, prev_cal}, {31'd0, e[8]});
        end
        check($sformatf("valid_gap#%0d", upd_idx), {31'd0, prev_valid}, 32'd0);
      end
      prev_valid = STICK_VALID;
      prev_cal   = CAL_DONE;
    end
  end

  initial begin
    RESET   = 1'b0;
    ADC_IN  = 8'h00;
    CAL_REQ = 1'b0;
    repeat (3) @(posedge CLK); #1;
    RESET = 1'b1;

    // Fill with 0xA0: only the 4th and 5th captures produce updates.
    for (int i = 0; i < 3; i++) sample(8'hA0, 1'b0, 8'h00, 1'b0, 1'b0);
    sample(8'hA0, 1'b1, 8'hA0, 1'b0, 1'b0);
    sample(8'hA0, 1'b1, 8'hA0, 1'b0, 1'b0);
    repeat (3) @(posedge CLK);
    #3;
    check("pre_reset_out", {24'd0, STICK_OUT}, 32'h0A0);
    RESET = 1'b0;
    exp_q.delete();
    #1;
    check("reset_out", {24'd0, STICK_OUT}, 32'h080);
    check("reset_valid", {31'd0, STICK_VALID}, 32'd0);
    check("reset_cal", {31'd0, CAL_DONE}, 32'd0);
    repeat (2) @(posedge CLK); #1;
    RESET = 1'b1;

    // First update after release must land on edge 34.
    exp_q.push_back({1'b0, 8'hA0});
    exp_q.push_back({1'b0, 8'hA0});
    first_valid = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge CLK); #1;
      if (STICK_VALID && first_valid < 0) first_valid = c;
    end
    check("first_valid_cycle", first_valid, 32'd34);

    // {cal, adc, expected stick_out}
    vecs = '{
      {1'b0, 8'h84, 8'h99}, {1'b0, 8'h84, 8'h92}, {1'b0, 8'h84, 8'h8B}, {1'b0, 8'h84, 8'h80},
      {1'b0, 8'h85, 8'h80}, {1'b0, 8'h85, 8'h80}, {1'b0, 8'h85, 8'h80}, {1'b0, 8'h85, 8'h85},
      {1'b0, 8'h7C, 8'h80}, {1'b0, 8'h7C, 8'h80}, {1'b0, 8'h7C, 8'h80}, {1'b0, 8'h7C, 8'h80},
      {1'b0, 8'h7B, 8'h7B}, {1'b0, 8'h7B, 8'h7B}, {1'b0, 8'h7B, 8'h7B}, {1'b0, 8'h7B, 8'h7B},
      {1'b0, 8'h80, 8'h80}, {1'b0, 8'h80, 8'h80}, {1'b0, 8'h80, 8'h80}, {1'b0, 8'h90, 8'h80},
      {1'b0, 8'h90, 8'h88},
      {1'b0, 8'h40, 8'h78}, {1'b0, 8'h40, 8'h68}, {1'b0, 8'h40, 8'h54}, {1'b0, 8'h40, 8'h40},
      {1'b0, 8'h40, 8'h40}, {1'b0, 8'h40, 8'h40}, {1'b0, 8'h40, 8'h40}, {1'b0, 8'h40, 8'h40},
      {1'b0, 8'h90, 8'h54}, {1'b0, 8'h90, 8'h68}, {1'b0, 8'h90, 8'h80}, {1'b0, 8'h90, 8'h90},
      {1'b1, 8'h90, 8'h80}, {1'b0, 8'h90, 8'h80}, {1'b0, 8'h90, 8'h80},
      {1'b0, 8'h00, 8'h5C}, {1'b0, 8'h00, 8'h38}, {1'b0, 8'h00, 8'h14}, {1'b0, 8'h00, 8'h00},
      {1'b0, 8'h40, 8'h00}, {1'b0, 8'h40, 8'h10}, {1'b0, 8'h40, 8'h20}, {1'b0, 8'h40, 8'h30},
      {1'b1, 8'h40, 8'h80},
      {1'b0, 8'hFF, 8'hAF}, {1'b0, 8'hFF, 8'hDF}, {1'b0, 8'hFF, 8'hFF}, {1'b0, 8'hFF, 8'hFF}
    };
    foreach (vecs[i]) sample(vecs[i][15:8], 1'b1, vecs[i][7:0], vecs[i][16], vecs[i][16]);
    repeat (3) @(posedge CLK);
    check("queue_drained", exp_q.size(), 32'd0);

    // Calibration requested during fill<4, plus merged extra edges.
    #3;
    RESET = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge CLK); #1;
    RESET  = 1'b1;
    ADC_IN = 8'h70;
    exp_q.push_back({1'b1, 8'h80});
    exp_q.push_back({1'b0, 8'h80});
    repeat (5) @(posedge CLK); #1;
    CAL_REQ = 1'b1;
    @(posedge CLK); #1;
    CAL_REQ = 1'b0;
    repeat (3) begin
      @(posedge CLK); #1;
      CAL_REQ = 1'b1;
      @(posedge CLK); #1;
      CAL_REQ = 1'b0;
    end
    repeat (28) @(posedge CLK);
    repeat (4) @(posedge CLK); #1;

    check("queue_empty", exp_q.size(), 32'd0);
    check("cal_done_count", cal_seen, 32'd3);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
